// File: rtl/mc_control_fsm_if.sv
// Control/status bundle between the multi-cycle MIPS sequencer (master) and
// the datapath side (slave): instruction/memory status in, strobes and selects out.
interface mc_control_fsm_if #(
  parameter int STATE_W = 4
);
  logic               run;
  logic [5:0]         opcode;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         ALUOp;
  logic [1:0]         pc_src;
  logic               done;
  logic               illegal_op;
  logic [STATE_W-1:0] state;

  modport master (
    input  run, opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, ALUOp,
           pc_src, done, illegal_op, state
  );

  modport slave (
    output run, opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, ALUOp,
           pc_src, done, illegal_op, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-32 main control sequencer: fetch/decode/execute/writeback, one instruction at a time.
// Optional feature: define MC_ADDI_EN to decode addi (opcode 001000) through ADDIEX/ADDIWB.
module mc_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  mc_control_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
`ifdef MC_ADDI_EN
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
`endif
    JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Moore part of the output set, plus flags marking the states with mem_ready-qualified terms.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       done;
    logic       in_fetch;
    logic       in_decode;
    logic       in_memwr;
  } ctrl_t;

  state_t state_r;
  state_t nxt_s;
  state_t after_final_s;
  ctrl_t  ctrl_r;

  function automatic logic opcode_legal(input logic [5:0] op);
    logic ok;
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: ok = 1'b1;
`ifdef MC_ADDI_EN
      OP_ADDI:                             ok = 1'b1;
`endif
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic ctrl_t decode_outs(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      IDLE: c = '0;
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.in_fetch  = 1'b1;
      end
      DECODE: begin
        c.alu_src_b = 2'b11;
        c.in_decode = 1'b1;
      end
      MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.done       = 1'b1;
      end
      MEMWR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
        c.in_memwr  = 1'b1;
      end
      EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.done      = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_src        = 2'b01;
        c.done          = 1'b1;
      end
`ifdef MC_ADDI_EN
      ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      ADDIWB: begin
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
`endif
      JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'b10;
        c.done     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Where an instruction's final state (or an illegal decode) goes: keep issuing while run is high.
  always_comb begin
    if (bus.run) begin
      after_final_s = FETCH;
    end else begin
      after_final_s = IDLE;
    end
  end

  // Next-state selection; run is only looked at in IDLE and in final states.
  always_comb begin
    nxt_s = IDLE;
    case (state_r)
      IDLE: begin
        if (bus.run) nxt_s = FETCH;
        else         nxt_s = IDLE;
      end
      FETCH: begin
        if (bus.mem_ready) nxt_s = DECODE;
        else               nxt_s = FETCH;
      end
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: nxt_s = MEMADR;
          OP_RTYPE:     nxt_s = EXEC;
          OP_BEQ:       nxt_s = BRANCH;
          OP_J:         nxt_s = JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      nxt_s = ADDIEX;
`endif
          default:      nxt_s = after_final_s;
        endcase
      end
      MEMADR: begin
        if (bus.opcode == OP_LW) nxt_s = MEMRD;
        else                     nxt_s = MEMWR;
      end
      MEMRD: begin
        if (bus.mem_ready) nxt_s = MEMWB;
        else               nxt_s = MEMRD;
      end
      MEMWR: begin
        if (bus.mem_ready) nxt_s = after_final_s;
        else               nxt_s = MEMWR;
      end
      EXEC:   nxt_s = ALUWB;
`ifdef MC_ADDI_EN
      ADDIEX: nxt_s = ADDIWB;
      ADDIWB: nxt_s = after_final_s;
`endif
      MEMWB, ALUWB, BRANCH, JUMP: nxt_s = after_final_s;
      default: nxt_s = IDLE;
    endcase
  end

  // State register with outputs pre-decoded for the state being entered, so they stay glitch-free.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
      ctrl_r  <= '0;
    end else begin
      state_r <= nxt_s;
      ctrl_r  <= decode_outs(nxt_s);
    end
  end

  assign bus.pc_write      = ctrl_r.pc_write | (ctrl_r.in_fetch & bus.mem_ready);
  assign bus.ir_write      = ctrl_r.in_fetch & bus.mem_ready;
  assign bus.done          = ctrl_r.done | (ctrl_r.in_memwr & bus.mem_ready);
  assign bus.illegal_op    = ctrl_r.in_decode & ~opcode_legal(bus.opcode);
  assign bus.pc_write_cond = ctrl_r.pc_write_cond;
  assign bus.i_or_d        = ctrl_r.i_or_d;
  assign bus.mem_read      = ctrl_r.mem_read;
  assign bus.mem_write     = ctrl_r.mem_write;
  assign bus.mem_to_reg    = ctrl_r.mem_to_reg;
  assign bus.reg_dst       = ctrl_r.reg_dst;
  assign bus.reg_write     = ctrl_r.reg_write;
  assign bus.alu_src_a     = ctrl_r.alu_src_a;
  assign bus.alu_src_b     = ctrl_r.alu_src_b;
  assign bus.ALUOp         = ctrl_r.alu_op;
  assign bus.pc_src        = ctrl_r.pc_src;
  assign bus.state         = STATE_W'(state_r);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: randomized instruction stream, per-instruction
// expectations from the latency/strobe rules, checked by a negedge monitor at each done/illegal_op pulse.
module tb_mc_control_fsm;
  localparam int STATE_W = 4;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mc_control_fsm_if #(.STATE_W(STATE_W)) bus();
  mc_control_fsm #(.STATE_W(STATE_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    int idle;
    int cycles;
    bit illegal;
    int fin_state;
    int n_mem_read;
    int n_ir_write;
    int n_pc_write;
    int n_reg_write;
    int n_mem_write;
    int n_pwc;
    int n_alu_sub;
    int n_alu_funct;
    int n_srcb_imm;
    bit m2r;
    bit rdst;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  bit prev_run = 1'b0;
  int a_idle, a_cyc, a_mr, a_ir, a_pcw, a_rw, a_mw, a_pwc, a_sub, a_fun, a_imm;
  bit idle_bad;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [17:0] outs_now();
    return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.ALUOp, bus.pc_src, bus.done, bus.illegal_op};
  endfunction

  task automatic clear_acc();
    a_idle = 0; a_cyc = 0; a_mr = 0; a_ir = 0; a_pcw = 0; a_rw = 0;
    a_mw = 0; a_pwc = 0; a_sub = 0; a_fun = 0; a_imm = 0; idle_bad = 1'b0;
  endtask

  // Monitor: accumulate strobe activity per instruction, compare against the queue head at each pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.state == '0) begin
        a_idle++;
        if (outs_now() != 18'd0) idle_bad = 1'b1;
      end else begin
        a_cyc++;
        a_mr  += int'(bus.mem_read);
        a_ir  += int'(bus.ir_write);
        a_pcw += int'(bus.pc_write);
        a_rw  += int'(bus.reg_write);
        a_mw  += int'(bus.mem_write);
        a_pwc += int'(bus.pc_write_cond);
        a_sub += int'(bus.ALUOp == 2'b01);
        a_fun += int'(bus.ALUOp == 2'b10);
        a_imm += int'(bus.alu_src_b == 2'b10);
      end
      if (bus.done || bus.illegal_op) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("idle_cycles", a_idle, e.idle);
          check("idle_outputs_zero", int'(idle_bad), 0);
          check("latency", a_cyc, e.cycles);
          check("illegal_op", int'(bus.illegal_op), int'(e.illegal));
          check("done", int'(bus.done), int'(!e.illegal));
          check("final_state", int'(bus.state), e.fin_state);
          check("mem_read_cycles", a_mr, e.n_mem_read);
          check("ir_write_cycles", a_ir, e.n_ir_write);
          check("pc_write_cycles", a_pcw, e.n_pc_write);
          check("reg_write_cycles", a_rw, e.n_reg_write);
          check("mem_write_cycles", a_mw, e.n_mem_write);
          check("pc_write_cond_cycles", a_pwc, e.n_pwc);
          check("aluop_sub_cycles", a_sub, e.n_alu_sub);
          check("aluop_funct_cycles", a_fun, e.n_alu_funct);
          check("srcb_imm_cycles", a_imm, e.n_srcb_imm);
          check("mem_to_reg_at_done", int'(bus.mem_to_reg), int'(e.m2r));
          check("reg_dst_at_done", int'(bus.reg_dst), int'(e.rdst));
        end
        clear_acc();
      end else if (a_cyc > 60) begin
        check("watchdog_no_pulse", a_cyc, 0);
        clear_acc();
      end
    end
  end

  task automatic cyc(input bit mr, input bit rn, input logic [5:0] op);
    bus.mem_ready = mr;
    bus.run       = rn;
    bus.opcode    = op;
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction: push its expected outcome, then drive a precomputed mem_ready/run/opcode plan.
  task automatic issue(input logic [5:0] op, input int f, input int m, input bit run_end);
    exp_t x;
    bit lw, sw, rt, bq, jp, ad, il;
    bit mr_q[$];
    int k, n;
    lw = (op == OP_LW); sw = (op == OP_SW); rt = (op == OP_RTYPE);
    bq = (op == OP_BEQ); jp = (op == OP_J);
`ifdef MC_ADDI_EN
    ad = (op == OP_ADDI);
`else
    ad = 1'b0;
`endif
    il = !(lw || sw || rt || bq || jp || ad);
    k = prev_run ? 0 : int'($urandom_range(1, 3));

    x.idle        = k;
    x.illegal     = il;
    x.cycles      = (lw ? 5 : (sw || rt || ad) ? 4 : (bq || jp) ? 3 : 2) + f + ((lw || sw) ? m : 0);
    x.fin_state   = lw ? 5 : sw ? 6 : rt ? 8 : ad ? 11 : bq ? 9 : jp ? 12 : 2;
    x.n_mem_read  = f + 1 + (lw ? m + 1 : 0);
    x.n_ir_write  = 1;
    x.n_pc_write  = 1 + int'(jp);
    x.n_reg_write = int'(lw || rt || ad);
    x.n_mem_write = sw ? m + 1 : 0;
    x.n_pwc       = int'(bq);
    x.n_alu_sub   = int'(bq);
    x.n_alu_funct = int'(rt);
    x.n_srcb_imm  = int'(lw || sw || ad);
    x.m2r         = lw;
    x.rdst        = rt;
    exp_q.push_back(x);

    for (int j = 0; j < k; j++) cyc(1'($urandom_range(0, 1)), (j == k - 1), 6'($urandom));

    for (int i = 0; i < f; i++) mr_q.push_back(1'b0);
    mr_q.push_back(1'b1);
    mr_q.push_back(1'($urandom_range(0, 1)));
    if (lw || sw) begin
      mr_q.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i < m; i++) mr_q.push_back(1'b0);
      mr_q.push_back(1'b1);
      if (lw) mr_q.push_back(1'($urandom_range(0, 1)));
    end else if (rt || ad) begin
      mr_q.push_back(1'($urandom_range(0, 1)));
      mr_q.push_back(1'($urandom_range(0, 1)));
    end else if (bq || jp) begin
      mr_q.push_back(1'($urandom_range(0, 1)));
    end
    n = mr_q.size();
    for (int i = 0; i < n; i++) begin
      cyc(mr_q[i], (i == n - 1) ? run_end : 1'($urandom_range(0, 1)),
          (i < f + 1) ? 6'($urandom) : op);
    end
    prev_run = run_end;
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] op;
    case ($urandom_range(0, 6))
      0: op = OP_LW;
      1: op = OP_SW;
      2: op = OP_RTYPE;
      3: op = OP_BEQ;
      4: op = OP_J;
      5: op = OP_ADDI;
      default: begin
        op = 6'($urandom);
        while (op == OP_LW || op == OP_SW || op == OP_RTYPE || op == OP_BEQ ||
               op == OP_J || op == OP_ADDI) op = 6'($urandom);
      end
    endcase
    return op;
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    clear_acc();
    reset_n = 1'b0;
    cyc(1'b0, 1'b1, OP_RTYPE);
    cyc(1'b1, 1'b1, OP_RTYPE);
    check("reset_state", int'(bus.state), 0);
    check("reset_outputs", int'(outs_now()), 0);
    reset_n = 1'b1;
    cyc(1'b0, 1'b1, OP_RTYPE);
    check("release_to_fetch", int'(bus.state), 1);

    reset_n = 1'b0;
    cyc(1'b0, 1'b0, OP_RTYPE);
    reset_n = 1'b1;
    prev_run = 1'b0;
    mon_en = 1'b1;

    issue(OP_RTYPE, 0, 0, 1'b1);
    issue(OP_LW, 0, 2, 1'b1);
    issue(OP_BEQ, 0, 0, 1'b0);
    issue(6'b111111, 0, 0, 1'b1);
    issue(OP_ADDI, 1, 0, 1'b1);
    issue(OP_SW, 0, 1, 1'b1);
    issue(OP_J, 2, 0, 1'b1);
    for (int t = 0; t < 40; t++) begin
      issue(pick_op(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
            ($urandom_range(0, 9) < 7));
    end
    issue(OP_RTYPE, 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, OP_RTYPE);
    check("queue_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    // Reset while an lw is stalled in MEMRD: instruction is abandoned with no done.
    cyc(1'b0, 1'b1, OP_LW);
    cyc(1'b1, 1'b1, OP_LW);
    cyc(1'b0, 1'b1, OP_LW);
    cyc(1'b0, 1'b1, OP_LW);
    cyc(1'b0, 1'b1, OP_LW);
    check("memrd_stall_state", int'(bus.state), 4);
    check("memrd_strobes", int'({bus.mem_read, bus.i_or_d}), 3);
    reset_n = 1'b0;
    cyc(1'b1, 1'b1, OP_LW);
    check("midreset_state", int'(bus.state), 0);
    check("midreset_outputs", int'(outs_now()), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, OP_LW);
      check("post_reset_idle_state", int'(bus.state), 0);
      check("post_reset_no_done", int'(bus.done), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
